// File: rtl/etpu_wb_pkg.sv
// Shared Wishbone widths and initiator state encoding for the edu_tpu bus path.
package etpu_wb_pkg;

   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_e;

endpackage

// File: rtl/etpu_wb_timer.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last allowed cycle.
module etpu_wb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int            TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Counter stops at LAST so it can never wrap back into a valid window.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if ((TIMEOUT != 0) && en_i && !expired_o)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/etpu_wb_initiator.sv
// Wishbone classic initiator: one command in, one bus cycle, one response out.
module etpu_wb_initiator
   import etpu_wb_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_W,
   parameter int DATA_W  = WB_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [ADDR_W-1:0]   cmd_adr,
   input  logic [DATA_W-1:0]   cmd_dat,
   input  logic [DATA_W/8-1:0] cmd_sel,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_dat,
   output logic                rsp_err,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [DATA_W/8-1:0] wbm_sel_o,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   input  logic                wbm_ack_i,
   input  logic [DATA_W-1:0]   wbm_dat_i,
   output logic [7:0]          timeout_cnt
);

   localparam int SEL_W = DATA_W / 8;

   wb_state_e         state_q;
   logic              cyc_q, stb_q, we_q;
   logic [SEL_W-1:0]  sel_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic              rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_dat_q;
   logic [7:0]        timeout_cnt_q;
   logic [7:0]        timeout_cnt_d;
   logic              tmr_expired;

   etpu_wb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .clear_i   (state_q == IDLE),
      .en_i      (state_q == BUS),
      .expired_o (tmr_expired)
   );

   assign timeout_cnt_d = (timeout_cnt_q == 8'hFF) ? timeout_cnt_q : timeout_cnt_q + 8'd1;

   // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q       <= IDLE;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         we_q          <= 1'b0;
         sel_q         <= '0;
         adr_q         <= '0;
         dat_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_dat_q     <= '0;
         timeout_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= cmd_we;
                  sel_q   <= cmd_sel;
                  adr_q   <= cmd_adr;
                  dat_q   <= cmd_dat;
                  state_q <= BUS;
               end
            end
            BUS: begin
               // Ack is tested first so a same-cycle ack beats the timeout.
               if (wbm_ack_i) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  we_q        <= 1'b0;
                  rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (tmr_expired) begin
                  cyc_q         <= 1'b0;
                  stb_q         <= 1'b0;
                  we_q          <= 1'b0;
                  rsp_dat_q     <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  timeout_cnt_q <= timeout_cnt_d;
                  state_q       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;
   assign rsp_err     = rsp_err_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_etpu_wb_initiator.sv
// Scoreboard bench for etpu_wb_initiator with a scripted Wishbone responder.
module tb_etpu_wb_initiator;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = '0;
   logic [7:0]  timeout_cnt;

   typedef struct packed {
      logic        err;
      logic [31:0] dat;
   } rsp_t;

   rsp_t sb_q[$];
   int   n_vec = 0;
   int   n_mis = 0;
   int   exp_tcnt = 0;

   always #5 clk = ~clk;

   etpu_wb_initiator #(.TIMEOUT(TMO)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_dat    (rsp_dat),
      .rsp_err    (rsp_err),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_we_o   (we),
      .wbm_sel_o  (sel),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_ack_i  (ack),
      .wbm_dat_i  (dat_i),
      .timeout_cnt(timeout_cnt)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: a response is consumed at the edge following a negedge with valid & ready.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("stray_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_err", 64'(rsp_err), 64'(e.err));
               check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
            end
         end
      end
   end

   task automatic check_bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      check("bus_cycstb", {62'd0, cyc, stb}, 64'd3);
      check("bus_we", 64'(we), 64'(w));
      check("bus_adr", 64'(adr), 64'(a));
      check("bus_dat", 64'(dat_o), 64'(d));
      check("bus_sel", 64'(sel), 64'(s));
   endtask

   // waits < 0 means the responder never acks and the transaction must time out.
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int waits, input logic [31:0] rd);
      int   n;
      rsp_t e;
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
      tick();
      cmd_valid = 1'b0;
      e.err = (waits < 0);
      e.dat = (waits < 0 || w) ? 32'd0 : rd;
      sb_q.push_back(e);
      if (waits >= 0) begin
         for (int i = 0; i < waits; i++) begin
            check_bus(w, a, d, s);
            tick();
         end
         check_bus(w, a, d, s);
         ack = 1'b1; dat_i = rd;
         tick();
         ack = 1'b0; dat_i = $urandom;
         check("ack_drop", {61'd0, cyc, stb, we}, 64'd0);
         check("rsp_latency", 64'(rsp_valid), 64'd1);
      end else begin
         n = 0;
         while (stb && n < 40) begin n++; tick(); end
         check("stb_cycles", 64'(n), 64'(TMO));
         check("to_cycdrop", {62'd0, cyc, stb}, 64'd0);
         check("to_rsp_valid", 64'(rsp_valid), 64'd1);
         if (exp_tcnt < 255) exp_tcnt++;
         check("timeout_cnt", 64'(timeout_cnt), 64'(exp_tcnt));
      end
      if (rsp_ready) begin
         n = 0;
         while (rsp_valid && n < 20) begin tick(); n++; end
         check("rsp_consumed", 64'(rsp_valid), 64'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] held;
      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_bus", {61'd0, cyc, stb, we}, 64'd0);
      check("rst_adr", 64'(adr), 64'd0);
      check("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
      check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
      check("rst_tcnt", 64'(timeout_cnt), 64'd0);

      // Write with two wait states, then zero-wait read
      run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'hFFFF_FFFF);
      run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h1234_5678);
      run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 1, 32'hA5A5_0F0F);

      // Timeout, then ack exactly on the timeout cycle
      run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 32'h0);
      run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, TMO - 1, 32'hCAFE_F00D);
      check("ack_wins_tcnt", 64'(timeout_cnt), 64'(exp_tcnt));

      // Back-pressure on the response
      rsp_ready = 1'b0;
      run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0BAD_F00D);
      held = rsp_dat;
      check("bp_dat", 64'(held), 64'h0BAD_F00D);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_dat_stable", 64'(rsp_dat), 64'(held));
         check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release_ready", 64'(cmd_ready), 64'd1);
      check("bp_release_valid", 64'(rsp_valid), 64'd0);
      run_txn(1'b1, 32'h3000_0024, 32'h5555_AAAA, 4'h9, 0, 32'h0);

      // Reset mid-transaction, then a stray ack
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_sel = 4'hF;
      tick();
      cmd_valid = 1'b0;
      check("mid_cyc", 64'(cyc), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_tcnt = 0;
      check("mid_rst_bus", {62'd0, cyc, stb}, 64'd0);
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_ready", 64'(cmd_ready), 64'd1);
      check("mid_rst_tcnt", 64'(timeout_cnt), 64'd0);
      ack = 1'b1; dat_i = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stray_ack_valid", 64'(rsp_valid), 64'd0);
         check("stray_ack_cyc", 64'(cyc), 64'd0);
      end
      ack = 1'b0;

      // Saturation of the timeout counter
      for (int i = 0; i < 300; i++)
         run_txn(1'b0, 32'h3000_0100 + 32'(i), 32'h0, 4'hF, -1, 32'h0);
      check("tcnt_sat", 64'(timeout_cnt), 64'd255);
      run_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, TMO - 1, 32'h1357_9BDF);
      check("tcnt_sat_hold", 64'(timeout_cnt), 64'd255);

      repeat (3) tick();
      check("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
